// File: rtl/cnn4ic_spi_pkg.sv
// Shared definitions for the SPI serial interface unit of the CNN accelerator.
// Holds the command bytes, sticky status bit positions, the frame-assembler
// state encoding and a byte bit-order helper.
package cnn4ic_spi_pkg;

  // Default geometry: 784 one-bit pixels, 8-bit SPI bytes, 16-bit weight address
  localparam int IMAGEWIDTH_DEF    = 784;
  localparam int DATAWIDTH_BUS_DEF = 8;
  localparam int ADDRESS_WIDTH_DEF = 16;
  localparam int IMG_BYTES         = IMAGEWIDTH_DEF / 8;

  // Command header bytes
  localparam logic [7:0] CMD_IMAGE   = 8'hA5;
  localparam logic [7:0] CMD_WEIGHT  = 8'h5A;
  localparam logic [7:0] CMD_CLRSTAT = 8'hC3;

  // Sticky status bit indices (bit4 is the live busy flag)
  localparam int STAT_FRAME_SHORT   = 0;
  localparam int STAT_BAD_CMD       = 1;
  localparam int STAT_OVERRUN       = 2;
  localparam int STAT_IMAGE_DROPPED = 3;
  localparam int STAT_BUSY          = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_IMG     = 3'd2,
    ST_W_AH    = 3'd3,
    ST_W_AL    = 3'd4,
    ST_W_D     = 3'd5,
    ST_DISCARD = 3'd6
  } state_e;

  // The wire sends the leftmost pixel first, i.e. in byte bit7, so each
  // byte is mirrored before it lands in the pixel vector.
  function automatic logic [7:0] reverse_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_image_shift_buffer.sv
// Shadow image register with a byte-addressed write port.
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset (clears image)
//   wr_en         - write strobe for one received image byte
//   wr_idx        - byte index k; byte lands on pixels [8k+7:8k]
//   wr_byte       - received byte, bit7 maps to pixel 8k
//   merged_image  - shadow contents with the current write already applied,
//                   so the completing byte can be published in the same cycle
module spi_image_shift_buffer
  import cnn4ic_spi_pkg::*;
#(
  parameter int IMAGEWIDTH = IMAGEWIDTH_DEF,
  parameter int IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [7:0]            wr_byte,
  output logic [IMAGEWIDTH-1:0] merged_image
);

  localparam int BYTES = IMAGEWIDTH / 8;

  logic [IMAGEWIDTH-1:0] shadow_r;
  logic [IDX_W+2:0]      base_s;

  assign base_s = {wr_idx, 3'b000};

  // Overlay the incoming byte onto the stored image
  always_comb begin
    merged_image = shadow_r;
    if (wr_en && (int'(wr_idx) < BYTES)) begin
      merged_image[base_s +: 8] = reverse_byte(wr_byte);
    end else begin
      merged_image = shadow_r;
    end
  end

  // Shadow image storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
    end else begin
      shadow_r <= merged_image;
    end
  end

endmodule

// File: rtl/spi_frame_assembler.sv
// SPI frame assembler: parses a command header from the synchronised SPI
// byte stream and assembles image frames or weight writes for the CNN core.
// Ports:
//   SPI_Frame_Assembler_CLOCK_50      - system clock
//   SPI_Frame_Assembler_RESET_InLow   - asynchronous active-low reset
//   SPI_Frame_Assembler_Frame_Active  - high while SS_N is asserted
//   SPI_Frame_Assembler_Byte_Valid    - one-cycle strobe per received byte
//   SPI_Frame_Assembler_Byte_InBUS    - received byte
//   SPI_Frame_Assembler_CNN_Busy      - CNN is processing an image
//   SPI_Frame_Assembler_Data_OutBUS   - last complete image, pixel i on bit i
//   SPI_Frame_Assembler_Weight_OutBUS - last weight data
//   SPI_Frame_Assembler_Addr_OutBUS   - last weight address
//   SPI_Frame_Assembler_Data_Ready    - one-cycle pulse on frame completion
//   SPI_Frame_Assembler_Is_Weight     - type of last completed frame
//   SPI_Frame_Assembler_Status_OutBUS - sticky status + busy flag
module spi_frame_assembler
  import cnn4ic_spi_pkg::*;
#(
  parameter int IMAGEWIDTH    = IMAGEWIDTH_DEF,
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                     SPI_Frame_Assembler_CLOCK_50,
  input  logic                     SPI_Frame_Assembler_RESET_InLow,
  input  logic                     SPI_Frame_Assembler_Frame_Active,
  input  logic                     SPI_Frame_Assembler_Byte_Valid,
  input  logic [7:0]               SPI_Frame_Assembler_Byte_InBUS,
  input  logic                     SPI_Frame_Assembler_CNN_Busy,
  output logic [IMAGEWIDTH-1:0]    SPI_Frame_Assembler_Data_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SPI_Frame_Assembler_Weight_OutBUS,
  output logic [ADDRESS_WIDTH-1:0] SPI_Frame_Assembler_Addr_OutBUS,
  output logic                     SPI_Frame_Assembler_Data_Ready,
  output logic                     SPI_Frame_Assembler_Is_Weight,
  output logic [7:0]               SPI_Frame_Assembler_Status_OutBUS
);

  localparam int N_BYTES = IMAGEWIDTH / 8;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic              active_r;
  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [7:0]        addr_hi_r;
  logic [7:0]        addr_lo_r;
  logic              done_r;
  logic [3:0]        sticky_r;

  logic              rise_s;
  logic              fall_s;
  logic              byte_ok_s;
  state_e            state_next_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              done_next_s;
  logic              img_done_s;
  logic              w_done_s;
  logic              buf_wr_s;
  logic [3:0]        sticky_next_s;
  logic [IMAGEWIDTH-1:0] merged_image_s;

  assign rise_s = SPI_Frame_Assembler_Frame_Active & ~active_r;
  assign fall_s = ~SPI_Frame_Assembler_Frame_Active & active_r;
  // A byte arriving together with the falling edge still belongs to the frame
  assign byte_ok_s = SPI_Frame_Assembler_Byte_Valid &
                     (SPI_Frame_Assembler_Frame_Active | active_r);

  spi_image_shift_buffer #(
    .IMAGEWIDTH (IMAGEWIDTH),
    .IDX_W      (CNT_W)
  ) u_image_buf (
    .clk          (SPI_Frame_Assembler_CLOCK_50),
    .rst_n        (SPI_Frame_Assembler_RESET_InLow),
    .wr_en        (buf_wr_s),
    .wr_idx       (cnt_r),
    .wr_byte      (SPI_Frame_Assembler_Byte_InBUS),
    .merged_image (merged_image_s)
  );

  // Next-state decode: process the byte first, then frame end / start
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    done_next_s   = done_r;
    img_done_s    = 1'b0;
    w_done_s      = 1'b0;
    buf_wr_s      = 1'b0;
    sticky_next_s = sticky_r;

    if (byte_ok_s) begin
      case (state_r)
        ST_CMD: begin
          case (SPI_Frame_Assembler_Byte_InBUS)
            CMD_IMAGE: begin
              state_next_s = ST_IMG;
              cnt_next_s   = '0;
            end
            CMD_WEIGHT: begin
              state_next_s = ST_W_AH;
            end
            CMD_CLRSTAT: begin
              sticky_next_s = 4'b0000;
              state_next_s  = ST_DISCARD;
            end
            default: begin
              sticky_next_s[STAT_BAD_CMD] = 1'b1;
              state_next_s                = ST_DISCARD;
            end
          endcase
        end
        ST_IMG: begin
          buf_wr_s   = 1'b1;
          cnt_next_s = cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(N_BYTES - 1)) begin
            img_done_s   = 1'b1;
            done_next_s  = 1'b1;
            state_next_s = ST_DISCARD;
          end else begin
            state_next_s = ST_IMG;
          end
        end
        ST_W_AH: state_next_s = ST_W_AL;
        ST_W_AL: state_next_s = ST_W_D;
        ST_W_D: begin
          w_done_s     = 1'b1;
          done_next_s  = 1'b1;
          state_next_s = ST_DISCARD;
        end
        ST_DISCARD: begin
          if (done_r) begin
            sticky_next_s[STAT_OVERRUN] = 1'b1;
          end else begin
            sticky_next_s = sticky_next_s;
          end
        end
        default: state_next_s = state_r;
      endcase
    end else begin
      state_next_s = state_r;
    end

    if (img_done_s && SPI_Frame_Assembler_CNN_Busy) begin
      sticky_next_s[STAT_IMAGE_DROPPED] = 1'b1;
    end else begin
      sticky_next_s = sticky_next_s;
    end

    if (fall_s) begin
      if ((state_next_s != ST_DISCARD) && (state_next_s != ST_IDLE)) begin
        sticky_next_s[STAT_FRAME_SHORT] = 1'b1;
      end else begin
        sticky_next_s = sticky_next_s;
      end
      state_next_s = ST_IDLE;
      done_next_s  = 1'b0;
    end else if (rise_s &&
                 ((state_next_s == ST_IDLE) || (state_next_s == ST_DISCARD))) begin
      // A rise seen in DISCARD means the previous end was missed
      state_next_s = ST_CMD;
      done_next_s  = 1'b0;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Frame FSM with registered handshake, data and status outputs
  always_ff @(posedge SPI_Frame_Assembler_CLOCK_50 or negedge SPI_Frame_Assembler_RESET_InLow) begin
    if (!SPI_Frame_Assembler_RESET_InLow) begin
      active_r                          <= 1'b0;
      state_r                           <= ST_IDLE;
      cnt_r                             <= '0;
      addr_hi_r                         <= 8'h00;
      addr_lo_r                         <= 8'h00;
      done_r                            <= 1'b0;
      sticky_r                          <= 4'b0000;
      SPI_Frame_Assembler_Data_OutBUS   <= '0;
      SPI_Frame_Assembler_Weight_OutBUS <= '0;
      SPI_Frame_Assembler_Addr_OutBUS   <= '0;
      SPI_Frame_Assembler_Data_Ready    <= 1'b0;
      SPI_Frame_Assembler_Is_Weight     <= 1'b0;
      SPI_Frame_Assembler_Status_OutBUS <= 8'h00;
    end else begin
      active_r <= SPI_Frame_Assembler_Frame_Active;
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      done_r   <= done_next_s;
      sticky_r <= sticky_next_s;
      SPI_Frame_Assembler_Status_OutBUS <=
        {3'b000, (state_next_s != ST_IDLE), sticky_next_s};
      SPI_Frame_Assembler_Data_Ready <= 1'b0;

      if (byte_ok_s && (state_r == ST_W_AH)) begin
        addr_hi_r <= SPI_Frame_Assembler_Byte_InBUS;
      end
      if (byte_ok_s && (state_r == ST_W_AL)) begin
        addr_lo_r <= SPI_Frame_Assembler_Byte_InBUS;
      end

      if (img_done_s && !SPI_Frame_Assembler_CNN_Busy) begin
        SPI_Frame_Assembler_Data_OutBUS <= merged_image_s;
        SPI_Frame_Assembler_Is_Weight   <= 1'b0;
        SPI_Frame_Assembler_Data_Ready  <= 1'b1;
      end
      if (w_done_s) begin
        SPI_Frame_Assembler_Addr_OutBUS   <= ADDRESS_WIDTH'({addr_hi_r, addr_lo_r});
        SPI_Frame_Assembler_Weight_OutBUS <= DATAWIDTH_BUS'(SPI_Frame_Assembler_Byte_InBUS);
        SPI_Frame_Assembler_Is_Weight     <= 1'b1;
        SPI_Frame_Assembler_Data_Ready    <= 1'b1;
      end
    end
  end

endmodule
